pic_ack_master: RTL and testbench



---
 rtl/pic_ack_master_if.sv | 37 +++
 rtl/pic_ack_master.sv | 191 +++++++++++++++++++
 tb/tb_pic_ack_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_ack_master_if.sv
// Host-side channels of pic_ack_master: register requests,
// register responses and interrupt vector delivery.
interface pic_ack_master_if;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_sel;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       vec_valid;
  logic [7:0] vec;
  logic       vec_ready;
`ifdef PIC_ACK_VEC_CHECK_EN
  logic       vec_err;
`endif

  modport master (
    output req_valid, req_write, req_sel, req_wdata,
    output vec_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  vec_valid, vec
`ifdef PIC_ACK_VEC_CHECK_EN
    , input vec_err
`endif
  );

  modport slave (
    input  req_valid, req_write, req_sel, req_wdata,
    input  vec_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output vec_valid, vec
`ifdef PIC_ACK_VEC_CHECK_EN
    , output vec_err
`endif
  );
endinterface

// File: rtl/pic_ack_master.sv
// CPU-side master for pic: register access and two-pulse intack.
// Define PIC_ACK_VEC_CHECK_EN to add the vec_err vector check.
module pic_ack_master #(
  parameter int ACK_LOW_CYCLES = 3,
  parameter int ACK_GAP_CYCLES = 2,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        int_in,
  output logic        intackN,
  output logic [1:0]  select,
  output logic        readwrite,
  inout  wire  [7:0]  data,
  pic_ack_master_if.slave host
);

  typedef enum logic [2:0] {
    IDLE, REG1, REG2, RSP,
    ACK1, GAP, ACK2, RECOV
  } state_t;

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       wr_q;
  logic [1:0] sel_q;
  logic       drv_q, drv_d;
  logic [7:0] dout_q, dout_d;

  logic       intackN_d;
  logic       readwrite_d;
  logic [1:0] select_d;
  logic       req_ready_d;
  logic       rsp_valid_d;
  logic [7:0] rsp_rdata_d;
  logic       vec_valid_d;
  logic [7:0] vec_d;
`ifdef PIC_ACK_VEC_CHECK_EN
  logic       vec_err_d;
`endif

  logic accept;
  logic start_ack;
  logic vec_cap;
  logic vec_take;

  assign data = drv_q ? dout_q : 8'hzz;

  // req_ready gates IDLE so nothing starts in the first cycle out of reset
  assign accept    = (state == IDLE) && host.req_ready
                   && host.req_valid;
  assign start_ack = (state == IDLE) && host.req_ready
                   && !host.req_valid && int_in
                   && !host.vec_valid;
  assign vec_cap   = (state == ACK2) && (cnt == 8'd0);
  assign vec_take  = host.vec_valid && host.vec_ready;

  // state, counter and all registered outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      wr_q           <= 1'b0;
      sel_q          <= 2'd0;
      drv_q          <= 1'b0;
      dout_q         <= 8'd0;
      intackN        <= 1'b1;
      readwrite      <= 1'b1;
      select         <= 2'd0;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= 8'd0;
      host.vec_valid <= 1'b0;
      host.vec       <= 8'd0;
`ifdef PIC_ACK_VEC_CHECK_EN
      host.vec_err   <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      drv_q          <= drv_d;
      dout_q         <= dout_d;
      intackN        <= intackN_d;
      readwrite      <= readwrite_d;
      select         <= select_d;
      host.req_ready <= req_ready_d;
      host.rsp_valid <= rsp_valid_d;
      host.rsp_rdata <= rsp_rdata_d;
      host.vec_valid <= vec_valid_d;
      host.vec       <= vec_d;
`ifdef PIC_ACK_VEC_CHECK_EN
      host.vec_err   <= vec_err_d;
`endif
      if (accept) begin
        wr_q  <= host.req_write;
        sel_q <= host.req_sel;
      end
    end
  end

  // sequencing: register access wins over a pending interrupt
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = REG1;
        end else if (start_ack) begin
          state_d = ACK1;
          cnt_d   = 8'(ACK_LOW_CYCLES - 1);
        end
      end
      REG1: state_d = REG2;
      REG2: state_d = RSP;
      RSP:  state_d = IDLE;
      ACK1: begin
        if (cnt == 8'd0) begin
          state_d = GAP;
          cnt_d   = 8'(ACK_GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_d = ACK2;
          cnt_d   = 8'(ACK_LOW_CYCLES - 1);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ACK2: begin
        if (cnt == 8'd0) begin
          state_d = RECOV;
          cnt_d   = 8'(RECOVER_CYCLES - 1);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      RECOV: begin
        if (cnt == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    intackN_d   = !((state_d == ACK1) || (state_d == ACK2));
    readwrite_d = 1'b1;
    select_d    = 2'd0;
    drv_d       = 1'b0;
    dout_d      = dout_q;
    if (accept) begin
      select_d    = host.req_sel;
      readwrite_d = !host.req_write;
      drv_d       = host.req_write;
      dout_d      = host.req_wdata;
    end else if (state == REG1) begin
      select_d = sel_q;
    end
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    rsp_rdata_d = host.rsp_rdata;
    if ((state == REG2) && !wr_q) begin
      rsp_rdata_d = data;
    end
    vec_valid_d = host.vec_valid;
    vec_d       = host.vec;
`ifdef PIC_ACK_VEC_CHECK_EN
    vec_err_d   = host.vec_err;
`endif
    if (vec_cap) begin
      vec_valid_d = 1'b1;
      vec_d       = data;
`ifdef PIC_ACK_VEC_CHECK_EN
      vec_err_d   = (data[7:3] != 5'b10100);
`endif
    end else if (vec_take) begin
      vec_valid_d = 1'b0;
`ifdef PIC_ACK_VEC_CHECK_EN
      vec_err_d   = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pic_ack_master.sv
// Bench for pic_ack_master with a small behavioural pic model,
// a response/vector scoreboard and an intack waveform monitor.
module tb_pic_ack_master;
  localparam int A = 3;
  localparam int G = 2;
  localparam int R = 3;
  localparam logic [1:0] SEL_IMR = 2'd1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic       int_in;
  logic       intackN;
  logic       readwrite;
  logic [1:0] select;
  wire  [7:0] data;

  pic_ack_master_if bus();

  pic_ack_master #(
    .ACK_LOW_CYCLES(A),
    .ACK_GAP_CYCLES(G),
    .RECOVER_CYCLES(R)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .int_in(int_in),
    .intackN(intackN),
    .select(select),
    .readwrite(readwrite),
    .data(data),
    .host(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // ---- behavioural pic ----
  logic [7:0] imr, irr, raise, force_val;
  logic       force_en;
  logic       prev_ack, vdrv;
  int         npulse;
  logic [2:0] idx;
  wire  [7:0] clr;
  wire  [7:0] vec_out;
  wire        pic_drv;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  assign clr = (!prev_ack && intackN && npulse == 2)
             ? (8'd1 << idx) : 8'd0;
  assign vec_out = force_en ? force_val : {5'b10100, idx};
  assign pic_drv = readwrite && (select == SEL_IMR || vdrv);
  assign data = pic_drv ? (vdrv ? vec_out : imr) : 8'hzz;

  always @(posedge clk) begin
    if (!resetN) begin
      imr <= 8'd0; irr <= 8'd0; int_in <= 1'b0;
      prev_ack <= 1'b1; npulse <= 0; vdrv <= 1'b0; idx <= 3'd0;
    end else begin
      prev_ack <= intackN;
      if (!readwrite && select == SEL_IMR) imr <= data;
      if (prev_ack && !intackN) begin
        if (npulse == 0) begin
          idx <= lowest(irr & imr);
          npulse <= 1;
        end else begin
          npulse <= 2;
          vdrv <= 1'b1;
        end
      end
      if (clr != 8'd0) begin
        npulse <= 0;
        vdrv <= 1'b0;
      end
      irr <= (irr & ~clr) | raise;
      int_in <= |(irr & imr);
    end
  end

  // ---- scoreboard ----
  typedef struct { logic rd; logic [7:0] d; int acc; } rsp_t;
  typedef struct { logic [7:0] v; logic e; } vexp_t;
  rsp_t  rq[$];
  vexp_t vq[$];
  rsp_t  mr;
  vexp_t mv;
  logic [7:0] m_imr = 8'd0;
  int rdy_mode = 0;
  int last_rsp_cyc = 0;

  always @(negedge clk) begin
    if (resetN && bus.rsp_valid) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid expected none");
      end else begin
        mr = rq.pop_front();
        chk("rsp_latency", cyc, mr.acc + 2);
        if (mr.rd) chk("rsp_rdata", bus.rsp_rdata, mr.d);
        last_rsp_cyc = cyc;
      end
    end
    if (resetN && bus.vec_valid && bus.vec_ready) begin
      if (vq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL vec_unexpected: got %0h expected none", bus.vec);
      end else begin
        mv = vq.pop_front();
        chk("vec", bus.vec, mv.v);
`ifdef PIC_ACK_VEC_CHECK_EN
        chk("vec_err", bus.vec_err, mv.e);
`endif
      end
    end
  end

  // ---- intack waveform monitor ----
  int   run = 0, phase = 0, falls = 0, last_fall_cyc = 0;
  logic pa = 1'b1, pvv = 1'b0, had_seq = 1'b0;

  always @(negedge clk) begin
    if (!resetN) begin
      run = 0; pa = 1'b1; phase = 0; pvv = 1'b0; had_seq = 1'b0;
    end else begin
      if (intackN == pa) run++;
      else begin
        if (!pa) begin
          chk("ack_low_len", run, A);
          if (phase == 1) phase = 2;
          else if (phase == 3) begin
            chk("vec_valid_after_ack", bus.vec_valid, 1);
            phase = 0;
            had_seq = 1'b1;
          end
        end else begin
          if (phase == 2) begin
            chk("ack_gap_len", run, G);
            phase = 3;
          end else begin
            chk("ack_while_vec_valid", pvv, 0);
            if (had_seq) chk("recover_len", int'(run >= R + 1), 1);
            phase = 1;
            falls++;
            last_fall_cyc = cyc;
          end
        end
        run = 1;
      end
      pa = intackN;
      pvv = bus.vec_valid;
    end
  end

  // vec_ready changes just after the edge
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bus.vec_ready = 1'b1;
      1: bus.vec_ready = 1'($urandom_range(0, 1));
      default: bus.vec_ready = 1'b0;
    endcase
  end

  task automatic do_req(input logic w, input logic [1:0] s,
                        input logic [7:0] wd);
    int t;
    rsp_t r;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_sel = s;
    bus.req_wdata = wd;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: got no req_ready expected accept");
    end else begin
      r.rd = !w;
      r.d = m_imr;
      r.acc = cyc + 1;
      rq.push_back(r);
      if (w && s == SEL_IMR) m_imr = wd;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic raise_irq(input logic [7:0] bits);
    logic [7:0] b;
    vexp_t e;
    b = bits & m_imr;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        e.v = force_en ? force_val : (8'hA0 | 8'(i));
        e.e = (e.v[7:3] != 5'b10100);
        vq.push_back(e);
      end
    end
    raise = b;
    @(negedge clk);
    raise = 8'd0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || vq.size() != 0) && t < 800) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (rq.size() != 0 || vq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d rsp %0d vec left expected 0",
               rq.size(), vq.size());
    end
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, t;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_sel = 2'd0;
    bus.req_wdata = 8'd0;
    raise = 8'd0;
    force_en = 1'b0;
    force_val = 8'd0;

    repeat (3) @(negedge clk);
    chk("rst_intackN", intackN, 1);
    chk("rst_readwrite", readwrite, 1);
    chk("rst_select", select, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_vec_valid", bus.vec_valid, 0);
    chk("rst_vec", bus.vec, 0);
`ifdef PIC_ACK_VEC_CHECK_EN
    chk("rst_vec_err", bus.vec_err, 0);
`endif
    resetN = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);

    do_req(1'b1, SEL_IMR, 8'hA5);
    do_req(1'b0, SEL_IMR, 8'h00);
    do_req(1'b1, SEL_IMR, 8'hFF);
    drain();

    f0 = falls;
    raise_irq(8'h10);
    drain();
    chk("single_irq_seqs", falls - f0, 1);

    f0 = falls;
    raise_irq(8'h11);
    drain();
    chk("two_irq_seqs", falls - f0, 2);
    chk("int_in_low_after", int_in, 0);

    rdy_mode = 2;
    f0 = falls;
    raise_irq(8'h11);
    repeat (40) @(negedge clk);
    chk("held_vec_seqs", falls - f0, 1);
    chk("held_vec_valid", bus.vec_valid, 1);
    rdy_mode = 0;
    drain();
    chk("released_vec_seqs", falls - f0, 2);

    raise_irq(8'h04);
    t = 0;
    while (!int_in && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("int_in_rose", int_in, 1);
    do_req(1'b0, SEL_IMR, 8'h00);
    drain();
    chk("reg_before_ack", int'(last_fall_cyc > last_rsp_cyc), 1);

`ifdef PIC_ACK_VEC_CHECK_EN
    force_en = 1'b1;
    force_val = 8'h33;
    raise_irq(8'h01);
    drain();
    force_en = 1'b0;
`endif

    raise_irq(8'h02);
    t = 0;
    while (intackN && t < 40) begin
      @(negedge clk);
      t++;
    end
    while (!intackN && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("reached_gap", int'(t < 60), 1);
    resetN = 1'b0;
    @(negedge clk);
    chk("gap_rst_intackN", intackN, 1);
    chk("gap_rst_vec_valid", bus.vec_valid, 0);
    chk("gap_rst_req_ready", bus.req_ready, 0);
    chk("gap_rst_readwrite", readwrite, 1);
    vq.delete();
    m_imr = 8'd0;
    resetN = 1'b1;
    @(negedge clk);
    chk("gap_rst_idle", bus.req_ready, 1);
    repeat (6) @(negedge clk);
    chk("gap_rst_no_ack", intackN, 1);

    do_req(1'b1, SEL_IMR, 8'($urandom));
    for (int it = 0; it < 80; it++) begin
      rdy_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin
          if (vq.size() == 0) do_req(1'b1, SEL_IMR, 8'($urandom));
          else do_req(1'b0, SEL_IMR, 8'h00);
        end
        1: do_req(1'b0, SEL_IMR, 8'h00);
        2: begin
          if (vq.size() == 0) begin
            repeat (2) @(negedge clk);
            raise_irq(8'($urandom));
          end
        end
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
